mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arb_rr.sv | 13 +
 rtl/mem_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state and owner encodings for the two-port memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin pick between CPU and EXT.
// On a tie the port that did not own the last access wins.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic   i_elig_cpu,
    input  logic   i_elig_ext,
    input  owner_t i_last_owner,
    output owner_t o_grant
);
    assign o_grant = (i_elig_cpu && i_elig_ext) ? ((i_last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU)
                                                : (i_elig_cpu ? OWN_CPU : OWN_EXT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and EXT ports onto one synchronous-read memory,
// three cycles per access (IDLE grant -> ACCESS -> RESP with ack).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    state_t r_state, w_next;
    owner_t r_owner, r_last_owner, w_grant;
    logic   w_elig_cpu, w_elig_ext, w_start;

    // A port whose ack is high this cycle is blocked, so a held req is not re-granted.
    assign w_elig_cpu = cpu_req && !cpu_ack;
    assign w_elig_ext = ext_req && !ext_ack;
    assign w_start    = (r_state == IDLE) && (w_elig_cpu || w_elig_ext);

    mem_arb_rr u_rr (
        .i_elig_cpu   (w_elig_cpu),
        .i_elig_ext   (w_elig_ext),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE)   ? (w_start ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_EXT;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            cpu_rdata    <= '0;
            cpu_ack      <= 1'b0;
            ext_rdata    <= '0;
            ext_ack      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ext_ack <= 1'b0;
            if (w_start) begin
                mem_addr     <= (w_grant == OWN_CPU) ? cpu_addr  : ext_addr;
                mem_wdata    <= (w_grant == OWN_CPU) ? cpu_wdata : ext_wdata;
                mem_we       <= (w_grant == OWN_CPU) ? cpu_we    : ext_we;
                r_owner      <= w_grant;
                r_last_owner <= w_grant;
            end
            if (r_state == ACCESS) mem_we <= 1'b0;
            if (r_state == RESP) begin
                if (r_owner == OWN_CPU) begin
                    cpu_rdata <= mem_rdata;
                    cpu_ack   <= 1'b1;
                end else begin
                    ext_rdata <= mem_rdata;
                    ext_ack   <= 1'b1;
                end
            end
        end
    end
endmodule
